// File: rtl/cvxif_pkg.sv
// cvxif_pkg: CV-X-IF shared widths used by coprocessor blocks.
package cvxif_pkg;
    localparam int X_ID_WIDTH = 2;
endpackage

// File: rtl/mac_pkg.sv
// mac_pkg: slot states and per-ID storage layout for the MAC result scheduler.
package mac_pkg;
    import cvxif_pkg::*;
    localparam int MAC_DATA_W = 32;
    localparam int MAC_NR_IDS = 2**X_ID_WIDTH;
    typedef enum logic [2:0] {
        FREE,
        WAIT_BOTH,
        WAIT_COMMIT,
        WAIT_DATA,
        KILL_WAIT,
        PEND
    } slot_state_e;
    typedef struct packed {
        logic [4:0]            rd;
        logic                  we;
        logic [MAC_DATA_W-1:0] data;
    } slot_entry_t;
endpackage

// File: rtl/mac_result_scheduler_slot_fsm.sv
// mac_slot_fsm: lifecycle of one transaction ID from issue to result handshake.
module mac_slot_fsm
    import mac_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_issue,
    input  logic        i_commit,
    input  logic        i_kill,
    input  logic        i_done,
    input  logic        i_release,
    output slot_state_e o_state,
    output logic        o_pend,
    output logic        o_err
);
    slot_state_e r_state, w_next;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= FREE;
        else         r_state <= w_next;
    end

    // Events that make no sense in the current state are dropped and flagged.
    always_comb begin
        w_next = r_state;
        o_err  = 1'b0;
        case (r_state)
            FREE: begin
                w_next = i_issue ? WAIT_BOTH : FREE;
                o_err  = i_commit | i_done;
            end
            WAIT_BOTH: begin
                if (i_commit) w_next = i_kill ? (i_done ? FREE : KILL_WAIT) : (i_done ? PEND : WAIT_DATA);
                else if (i_done) w_next = WAIT_COMMIT;
            end
            WAIT_COMMIT: begin
                if (i_commit) w_next = i_kill ? FREE : PEND;
                o_err = i_done;
            end
            WAIT_DATA: begin
                w_next = i_done ? PEND : WAIT_DATA;
                o_err  = i_commit;
            end
            KILL_WAIT: begin
                w_next = i_done ? FREE : KILL_WAIT;
                o_err  = i_commit;
            end
            PEND: begin
                w_next = i_release ? FREE : PEND;
                o_err  = i_commit | i_done;
            end
            default: w_next = FREE;
        endcase
    end

    assign o_state = r_state;
    assign o_pend  = r_state == PEND;
endmodule

// File: rtl/mac_result_scheduler.sv
// mac_result_scheduler: per-ID writeback tracking with a round-robin
// arbitrated, single-entry CV-X-IF result register.
module mac_result_scheduler
    import cvxif_pkg::*;
    import mac_pkg::*;
#(
    parameter int NR_IDS = MAC_NR_IDS,
    parameter int DATA_W = MAC_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  issue_valid_i,
    input  logic [X_ID_WIDTH-1:0] issue_id_i,
    input  logic [4:0]            issue_rd_i,
    input  logic                  issue_we_i,
    output logic                  issue_ready_o,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    input  logic                  mac_done_i,
    input  logic [X_ID_WIDTH-1:0] mac_id_i,
    input  logic [DATA_W-1:0]     mac_data_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [X_ID_WIDTH-1:0] result_id_o,
    output logic [DATA_W-1:0]     result_data_o,
    output logic [4:0]            result_rd_o,
    output logic                  result_we_o,
    output logic                  busy_o,
    output logic                  protocol_err_o
);
    localparam logic [X_ID_WIDTH-1:0] ONE_ID = 1;

    slot_state_e           w_state [NR_IDS];
    logic [NR_IDS-1:0]     w_pend, w_cand, w_busy, w_slot_err;
    slot_entry_t           r_slot [NR_IDS];
    slot_entry_t           r_out;
    logic [X_ID_WIDTH-1:0] r_id, r_ptr, w_sel;
    logic                  r_valid, r_err, w_found, w_load, w_clash, w_issue_ok, w_take;

    assign issue_ready_o = w_state[issue_id_i] == FREE;
    assign w_issue_ok    = issue_valid_i && issue_ready_o;
    assign w_clash       = commit_valid_i && issue_valid_i && commit_id_i == issue_id_i;
    assign w_take        = mac_done_i && (w_state[mac_id_i] == WAIT_BOTH || w_state[mac_id_i] == WAIT_DATA);
    assign w_load        = !r_valid || result_ready_i;

    for (genvar g = 0; g < NR_IDS; g++) begin : g_slot
        mac_slot_fsm u_fsm (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .i_issue   (w_issue_ok && issue_id_i == X_ID_WIDTH'(g)),
            .i_commit  (commit_valid_i && !w_clash && commit_id_i == X_ID_WIDTH'(g)),
            .i_kill    (commit_kill_i),
            .i_done    (mac_done_i && mac_id_i == X_ID_WIDTH'(g)),
            .i_release (r_valid && result_ready_i && r_id == X_ID_WIDTH'(g)),
            .o_state   (w_state[g]),
            .o_pend    (w_pend[g]),
            .o_err     (w_slot_err[g])
        );
        assign w_cand[g] = w_pend[g] && !(r_valid && r_id == X_ID_WIDTH'(g));
        assign w_busy[g] = w_state[g] != FREE;
    end

    // Descending scan so the candidate closest to the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = NR_IDS - 1; k >= 0; k--) begin
            if (w_cand[r_ptr + X_ID_WIDTH'(k)]) begin
                w_found = 1'b1;
                w_sel   = r_ptr + X_ID_WIDTH'(k);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NR_IDS; k++) r_slot[k] <= '0;
        end else begin
            if (w_issue_ok) r_slot[issue_id_i] <= '{rd: issue_rd_i, we: issue_we_i, data: '0};
            if (w_take) r_slot[mac_id_i].data <= mac_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_out   <= '0;
            r_ptr   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= r_err | (issue_valid_i & ~issue_ready_o) | w_clash | (|w_slot_err);
            if (w_load) begin
                r_valid <= w_found;
                if (w_found) begin
                    r_id  <= w_sel;
                    r_out <= r_slot[w_sel];
                    r_ptr <= w_sel + ONE_ID;
                end
            end
        end
    end

    assign result_valid_o = r_valid;
    assign result_id_o    = r_id;
    assign result_rd_o    = r_out.rd;
    assign result_we_o    = r_out.we;
    assign result_data_o  = r_out.data;
    assign busy_o         = |w_busy;
    assign protocol_err_o = r_err;
endmodule

// File: tb/tb_mac_result_scheduler.sv
// tb_mac_result_scheduler: directed checks of slot lifecycle, round-robin order,
// backpressure, protocol errors and asynchronous reset.
module tb_mac_result_scheduler;
    import cvxif_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  issue_valid_i = 1'b0;
    logic [X_ID_WIDTH-1:0] issue_id_i = '0;
    logic [4:0]            issue_rd_i = '0;
    logic                  issue_we_i = 1'b0;
    logic                  issue_ready_o;
    logic                  commit_valid_i = 1'b0;
    logic [X_ID_WIDTH-1:0] commit_id_i = '0;
    logic                  commit_kill_i = 1'b0;
    logic                  mac_done_i = 1'b0;
    logic [X_ID_WIDTH-1:0] mac_id_i = '0;
    logic [31:0]           mac_data_i = '0;
    logic                  result_valid_o;
    logic                  result_ready_i = 1'b1;
    logic [X_ID_WIDTH-1:0] result_id_o;
    logic [31:0]           result_data_o;
    logic [4:0]            result_rd_o;
    logic                  result_we_o;
    logic                  busy_o;
    logic                  protocol_err_o;
    int                    errs = 0;
    int                    checks = 0;

    mac_result_scheduler dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .issue_valid_i  (issue_valid_i),
        .issue_id_i     (issue_id_i),
        .issue_rd_i     (issue_rd_i),
        .issue_we_i     (issue_we_i),
        .issue_ready_o  (issue_ready_o),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (commit_id_i),
        .commit_kill_i  (commit_kill_i),
        .mac_done_i     (mac_done_i),
        .mac_id_i       (mac_id_i),
        .mac_data_i     (mac_data_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_id_o    (result_id_o),
        .result_data_o  (result_data_o),
        .result_rd_o    (result_rd_o),
        .result_we_o    (result_we_o),
        .busy_o         (busy_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic iss(input logic [X_ID_WIDTH-1:0] id, input logic [4:0] rd, input logic we);
        issue_valid_i = 1'b1;
        issue_id_i = id;
        issue_rd_i = rd;
        issue_we_i = we;
        cyc();
        issue_valid_i = 1'b0;
    endtask

    task automatic cmt(input logic [X_ID_WIDTH-1:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i = id;
        commit_kill_i = kill;
        cyc();
        commit_valid_i = 1'b0;
    endtask

    task automatic done(input logic [X_ID_WIDTH-1:0] id, input logic [31:0] data);
        mac_done_i = 1'b1;
        mac_id_i = id;
        mac_data_i = data;
        cyc();
        mac_done_i = 1'b0;
    endtask

    task automatic chk_rdy(input string tag, input logic [X_ID_WIDTH-1:0] id, input logic exp);
        issue_id_i = id;
        #1;
        chk(tag, issue_ready_o, exp);
    endtask

    task automatic chk_res(input string tag, input logic [X_ID_WIDTH-1:0] id, input logic [4:0] rd,
                           input logic we, input logic [31:0] data);
        chk({tag, ".valid"}, result_valid_o, 1'b1);
        chk({tag, ".id"}, result_id_o, id);
        chk({tag, ".rd"}, result_rd_o, rd);
        chk({tag, ".we"}, result_we_o, we);
        chk({tag, ".data"}, result_data_o, data);
    endtask

    initial begin
        #3;
        chk("rst.valid", result_valid_o, 1'b0);
        chk("rst.data", result_data_o, 32'h0);
        chk("rst.busy", busy_o, 1'b0);
        chk("rst.err", protocol_err_o, 1'b0);
        chk_rdy("rst.rdy", 2'd1, 1'b1);
        cyc();
        rst_ni = 1'b1;
        cyc();

        iss(2'd1, 5'd5, 1'b1);
        chk("t1.busy", busy_o, 1'b1);
        cyc();
        cmt(2'd1, 1'b0);
        cyc();
        done(2'd1, 32'h0000_0007);
        chk("t1.latency", result_valid_o, 1'b0);
        cyc();
        chk_res("t1.res", 2'd1, 5'd5, 1'b1, 32'h7);
        chk_rdy("t1.rdy_hs", 2'd1, 1'b0);
        cyc();
        chk("t1.valid_off", result_valid_o, 1'b0);
        chk_rdy("t1.rdy_after", 2'd1, 1'b1);
        chk("t1.busy_off", busy_o, 1'b0);

        iss(2'd2, 5'd9, 1'b1);
        done(2'd2, 32'hDEAD_BEEF);
        chk("t2.valid_wc", result_valid_o, 1'b0);
        cmt(2'd2, 1'b1);
        cyc();
        chk("t2.valid", result_valid_o, 1'b0);
        chk("t2.busy", busy_o, 1'b0);
        chk("t2.err", protocol_err_o, 1'b0);
        chk_rdy("t2.rdy", 2'd2, 1'b1);

        iss(2'd3, 5'd4, 1'b1);
        cmt(2'd3, 1'b1);
        chk("t3.busy_kw", busy_o, 1'b1);
        chk_rdy("t3.rdy_kw", 2'd3, 1'b0);
        done(2'd3, 32'h1234_5678);
        chk("t3.busy", busy_o, 1'b0);
        cyc();
        chk("t3.valid", result_valid_o, 1'b0);
        chk("t3.err", protocol_err_o, 1'b0);

        result_ready_i = 1'b0;
        iss(2'd3, 5'd3, 1'b1);
        done(2'd3, 32'h33);
        cmt(2'd3, 1'b0);
        cyc();
        chk_res("t4.id3", 2'd3, 5'd3, 1'b1, 32'h33);
        iss(2'd0, 5'd10, 1'b1);
        iss(2'd1, 5'd11, 1'b1);
        iss(2'd2, 5'd12, 1'b1);
        cmt(2'd0, 1'b0);
        cmt(2'd1, 1'b0);
        cmt(2'd2, 1'b0);
        done(2'd0, 32'hA0);
        done(2'd1, 32'hA1);
        done(2'd2, 32'hA2);
        chk_res("t4.hold3", 2'd3, 5'd3, 1'b1, 32'h33);
        result_ready_i = 1'b1;
        cyc();
        chk_res("t4.rr0", 2'd0, 5'd10, 1'b1, 32'hA0);
        cyc();
        chk_res("t4.rr1", 2'd1, 5'd11, 1'b1, 32'hA1);
        cyc();
        chk_res("t4.rr2", 2'd2, 5'd12, 1'b1, 32'hA2);
        cyc();
        chk("t4.empty", result_valid_o, 1'b0);

        iss(2'd0, 5'd20, 1'b1);
        done(2'd0, 32'hB0);
        iss(2'd2, 5'd22, 1'b0);
        cmt(2'd2, 1'b0);
        commit_valid_i = 1'b1;
        commit_id_i = 2'd0;
        commit_kill_i = 1'b0;
        mac_done_i = 1'b1;
        mac_id_i = 2'd2;
        mac_data_i = 32'hB2;
        cyc();
        commit_valid_i = 1'b0;
        mac_done_i = 1'b0;
        cyc();
        chk_res("t5.wrap0", 2'd0, 5'd20, 1'b1, 32'hB0);
        cyc();
        chk_res("t5.next2", 2'd2, 5'd22, 1'b0, 32'hB2);
        cyc();
        chk("t5.empty", result_valid_o, 1'b0);

        result_ready_i = 1'b0;
        iss(2'd1, 5'd7, 1'b0);
        cmt(2'd1, 1'b0);
        done(2'd1, 32'h11);
        cyc();
        chk_res("t6.offer1", 2'd1, 5'd7, 1'b0, 32'h11);
        iss(2'd2, 5'd8, 1'b1);
        chk_res("t6.hold_a", 2'd1, 5'd7, 1'b0, 32'h11);
        cmt(2'd2, 1'b0);
        chk_res("t6.hold_b", 2'd1, 5'd7, 1'b0, 32'h11);
        done(2'd2, 32'h22);
        chk_res("t6.hold_c", 2'd1, 5'd7, 1'b0, 32'h11);
        cyc();
        chk_res("t6.hold_d", 2'd1, 5'd7, 1'b0, 32'h11);
        result_ready_i = 1'b1;
        cyc();
        chk_res("t6.offer2", 2'd2, 5'd8, 1'b1, 32'h22);
        cyc();
        chk("t6.empty", result_valid_o, 1'b0);
        chk("t6.err", protocol_err_o, 1'b0);

        done(2'd0, 32'h5);
        chk("t7.err_set", protocol_err_o, 1'b1);
        chk("t7.busy_ign", busy_o, 1'b0);
        cyc();
        cyc();
        chk("t7.err_sticky", protocol_err_o, 1'b1);
        result_ready_i = 1'b0;
        iss(2'd1, 5'd9, 1'b1);
        cmt(2'd1, 1'b0);
        done(2'd1, 32'h99);
        cyc();
        chk("t7.pre_valid", result_valid_o, 1'b1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("t7.rst_valid", result_valid_o, 1'b0);
        chk("t7.rst_id", result_id_o, 2'd0);
        chk("t7.rst_rd", result_rd_o, 5'd0);
        chk("t7.rst_we", result_we_o, 1'b0);
        chk("t7.rst_data", result_data_o, 32'h0);
        chk("t7.rst_busy", busy_o, 1'b0);
        chk("t7.rst_err", protocol_err_o, 1'b0);
        for (int i = 0; i < 4; i++) chk_rdy("t7.rst_rdy", 2'(i), 1'b1);
        cyc();
        rst_ni = 1'b1;
        result_ready_i = 1'b1;
        cyc();
        chk("t7.post_valid", result_valid_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
